// File: rtl/ser_tx.sv
// rtl/ser_tx.sv - parallel-load serial transmitter with ready/valid load handshake
// Every output is a register updated alongside the FSM, so no input reaches an output combinationally.
module ser_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             done,
    output logic [4:0]       bit_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [4:0]       r_cnt;
    logic             r_q;
    logic             r_q_valid;
    logic             r_done;
    logic             r_load_ready;
    logic [4:0]       r_bit_idx;

    logic [WIDTH-1:0] w_shifted;
    logic             w_first_bit;
    logic             w_next_bit;

    // Data moves toward the output end; vacated positions fill with zeros.
    assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
    assign w_first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign w_next_bit  = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_q          <= 1'b0;
            r_q_valid    <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
            r_bit_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_state      <= SHIFT;
                        r_shift      <= din;
                        r_cnt        <= '0;
                        r_q          <= w_first_bit;
                        r_q_valid    <= 1'b1;
                        r_load_ready <= 1'b0;
                        r_bit_idx    <= '0;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shifted;
                    if (r_cnt == LAST) begin
                        r_state   <= DONE;
                        r_cnt     <= '0;
                        r_q       <= 1'b0;
                        r_q_valid <= 1'b0;
                        r_done    <= 1'b1;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt     <= r_cnt + 5'd1;
                        r_q       <= w_next_bit;
                        r_bit_idx <= r_cnt + 5'd1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                end
                default: begin
                    r_state      <= IDLE;
                    r_shift      <= '0;
                    r_cnt        <= '0;
                    r_q          <= 1'b0;
                    r_q_valid    <= 1'b0;
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                    r_bit_idx    <= '0;
                end
            endcase
        end
    end

    assign q          = r_q;
    assign q_valid    = r_q_valid;
    assign done       = r_done;
    assign load_ready = r_load_ready;
    assign bit_idx    = r_bit_idx;

endmodule

// File: tb/tb_ser_tx.sv
// tb/tb_ser_tx.sv - randomized and directed bench for ser_tx against a frame-timeline model
module tb_ser_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] din;

    logic       a_ready, a_q, a_qv, a_done;
    logic [4:0] a_idx;
    logic       b_ready, b_q, b_qv, b_done;
    logic [4:0] b_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: m_t = 0 idle, 1..W = cycle carrying frame bit m_t-1, W+1 = done cycle.
    int           m_t    = 0;
    logic [W-1:0] m_word = '0;

    always #5 clk = ~clk;

    ser_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (a_ready),
        .q          (a_q),
        .q_valid    (a_qv),
        .done       (a_done),
        .bit_idx    (a_idx)
    );

    ser_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (b_ready),
        .q          (b_q),
        .q_valid    (b_qv),
        .done       (b_done),
        .bit_idx    (b_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Packed as {q, q_valid, done, load_ready, bit_idx}.
    function automatic logic [8:0] model_out(input bit msb);
        int         k;
        logic       qv, qb, dn, rd;
        logic [4:0] idx;
        qv  = (m_t >= 1) && (m_t <= W);
        k   = m_t - 1;
        qb  = 1'b0;
        idx = '0;
        if (qv) begin
            qb  = msb ? m_word[W-1-k] : m_word[k];
            idx = 5'(k);
        end
        dn = (m_t == W + 1);
        rd = (m_t == 0);
        return {qb, qv, dn, rd, idx};
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst)              m_t = 0;
        else if (m_t == 0) begin
            if (load_valid) begin
                m_t    = 1;
                m_word = din;
            end
        end
        else if (m_t == W + 1) m_t = 0;
        else                   m_t++;
        @(negedge clk);
        check({tag, "_msb"}, 32'({a_q, a_qv, a_done, a_ready, a_idx}), 32'(model_out(1'b1)));
        check({tag, "_lsb"}, 32'({b_q, b_qv, b_done, b_ready, b_idx}), 32'(model_out(1'b0)));
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        tick("reset");
        tick("reset");
        rst = 1'b0;
        tick("idle");

        // Single 1-cycle load of 8'h1E.
        din        = 8'h1E;
        load_valid = 1'b1;
        tick("f1e");
        load_valid = 1'b0;
        din        = '0;
        repeat (W + 3) tick("f1e");

        // Back-to-back frames with load_valid held high: FF then 00.
        din        = 8'hFF;
        load_valid = 1'b1;
        tick("b2b");
        din = 8'h00;
        repeat (W + 2) tick("b2b");
        load_valid = 1'b0;
        repeat (W + 4) tick("b2b");

        // din churns during the frame in flight.
        din        = 8'hA5;
        load_valid = 1'b1;
        tick("churn");
        load_valid = 1'b0;
        repeat (W + 3) begin
            din = W'($urandom);
            tick("churn");
        end

        // Reset while bit 3 is on the line.
        din        = 8'hC3;
        load_valid = 1'b1;
        tick("abort");
        load_valid = 1'b0;
        repeat (3) tick("abort");
        rst = 1'b1;
        tick("abort");
        rst = 1'b0;
        repeat (W + 3) tick("abort");

        // Reset and load on the same edge.
        rst        = 1'b1;
        load_valid = 1'b1;
        din        = 8'h5A;
        tick("rstld");
        rst        = 1'b0;
        load_valid = 1'b0;
        repeat (3) tick("rstld");

        repeat (3000) begin
            rst        = ($urandom_range(0, 99) == 0);
            load_valid = 1'($urandom_range(0, 1));
            din        = W'($urandom);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Parameters
REQ-001 WIDTH, default 8, number of bits per frame (legal range 2..32).
REQ-002 MSB_FIRST, default 1; 1 = shift out din[WIDTH-1] first, 0 = shift out din[0] first.

Interface
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  WIDTH  parallel word; sampled only on an accepted load.
REQ-006 load_valid  input  1  requester offers din this cycle.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 q  output  1  serial data out, one bit per clock.
REQ-009 q_valid  output  1  q carries a frame bit this cycle.
REQ-010 done  output  1  one-cycle pulse after the last bit of a frame.
REQ-011 bit_idx  output  5  index of the bit currently on q, counting from 0 in transmit order; 0 when q_valid=0.

Function
REQ-012 The FSM SHALL have exactly 3 states: IDLE, SHIFT, DONE.
REQ-013 A load SHALL be accepted on a rising edge where load_valid=1 and load_ready=1.
REQ-014 load_ready SHALL be 1 only in IDLE.
REQ-015 load_valid in SHIFT or DONE SHALL be ignored and SHALL NOT be lost-and-latched; the requester holds it until it sees load_ready.
REQ-016 On an accepted load: shift register <= din, bit counter <= 0, state <= SHIFT.
REQ-017 Latency: the first frame bit SHALL appear on q in the cycle immediately after the accept edge, with q_valid=1 and bit_idx=0.
REQ-018 In SHIFT, each edge SHALL advance the shift register by one position toward the output end and increment the bit counter.
REQ-019 When the counter equals WIDTH-1 at an edge, the state SHALL go to DONE; q_valid SHALL be 1 for exactly WIDTH consecutive cycles per frame.
REQ-020 MSB_FIRST=1: bit k of the frame (k=0..WIDTH-1) SHALL equal din[WIDTH-1-k]. MSB_FIRST=0: bit k SHALL equal din[k].
REQ-021 In DONE, done=1, q_valid=0, q=0 and load_ready=0 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-022 Minimum frame-to-frame spacing SHALL be WIDTH+2 cycles (WIDTH SHIFT cycles, 1 DONE cycle, 1 IDLE accept cycle).
REQ-023 In IDLE, q=0, q_valid=0, done=0 and bit_idx=0.
REQ-024 q, q_valid, done, load_ready and bit_idx SHALL be decoded from registered state only; there SHALL be no combinational path from any input to any output.
REQ-025 Changes on din outside the accept edge SHALL NOT affect the frame in flight.
REQ-026 Unused shift-register positions SHALL fill with 0 as data shifts out.

Reset
REQ-027 rst=1 at a rising edge SHALL force state to IDLE, clear the shift register and bit counter, and make every output 0 except load_ready (load_ready=1 after reset).
REQ-028 rst SHALL take priority over a simultaneous load and over any in-progress frame; an aborted frame SHALL NOT produce done.
REQ-029 After rst deasserts, a load SHALL be accepted on the first edge where load_valid=1.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, din=8'h1E, 1-cycle load_valid pulse -> q=0,0,0,1,1,1,1,0 on the next 8 cycles, bit_idx 0..7, q_valid=1 throughout, then done=1 for 1 cycle, then load_ready=1.
REQ-031 WIDTH=8, MSB_FIRST=0, din=8'h1E -> q=0,1,1,1,1,0,0,0 on the next 8 cycles, then done for 1 cycle.
REQ-032 load_valid held at 1 with din=8'hFF then 8'h00 -> frames start exactly 10 cycles apart; q=1 x8, gap of 2 cycles with q_valid=0, then q=0 x8; no bit lost or duplicated.
REQ-033 din changed to 8'h00 on every cycle of a frame loaded with 8'hA5 -> the transmitted bits still equal 8'hA5.
REQ-034 rst=1 asserted at bit_idx=3 of a frame -> on the next cycle q=0, q_valid=0, done=0, load_ready=1; no done pulse follows.
REQ-035 rst=1 and load_valid=1 on the same edge -> the load is not accepted; the state stays IDLE and q_valid stays 0.
